// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, state type and arithmetic helpers for the conv blocks
package conv_pkg;

  // Default geometry and widths shared by the conv datapath blocks
  localparam int CONV_K_DEF    = 3;
  localparam int CONV_X_BW_DEF = 8;
  localparam int CONV_W_BW_DEF = 8;
  localparam int CONV_I_BW_DEF = 19;
  localparam int CONV_O_BW_DEF = 19;

  // Working width of the saturation helper; wide enough for any sane accumulator
  localparam int CONV_SAT_W = 64;

  // Window state: IDLE means the next valid tap is tap 0
  typedef enum logic {
    CONV_IDLE  = 1'b0,
    CONV_ACCUM = 1'b1
  } conv_state_e;

  // Accumulator width: room for K*K full-scale products plus the partial sum, plus a sign guard
  function automatic int conv_acc_bw(input int i_bw, input int x_bw, input int w_bw, input int k);
    int grow;
    grow = x_bw + w_bw + $clog2(k * k);
    return ((i_bw > grow) ? i_bw : grow) + 1;
  endfunction

  // Clamp a sign-extended in_bw-bit value into the signed out_bw-bit range
  function automatic logic signed [CONV_SAT_W-1:0] conv_sat(
    input logic signed [CONV_SAT_W-1:0] v,
    input int                           in_bw,
    input int                           out_bw
  );
    logic signed [CONV_SAT_W-1:0] hi;
    logic signed [CONV_SAT_W-1:0] lo;
    hi = (64'sd1 <<< (out_bw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_bw - 1));
    if (in_bw <= out_bw) return v;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_mac_pe.sv
// rtl/conv_mac_pe.sv - two-stage multiply / accumulate element with first and last tap tags
module conv_mac_pe
  import conv_pkg::*;
#(
  parameter int X_BW   = CONV_X_BW_DEF,
  parameter int W_BW   = CONV_W_BW_DEF,
  parameter int I_BW   = CONV_I_BW_DEF,
  parameter int ACC_BW = 21
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic                     i_first,
  input  logic                     i_last,
  input  logic signed [X_BW-1:0]   i_x,
  input  logic signed [W_BW-1:0]   i_w,
  input  logic signed [I_BW-1:0]   i_psum,
  output logic signed [ACC_BW-1:0] o_acc,
  output logic                     o_p_valid,
  output logic                     o_done
);

  localparam int P_BW = X_BW + W_BW;

  logic signed [P_BW-1:0]   p_d;
  logic signed [P_BW-1:0]   p_q;
  logic signed [I_BW-1:0]   psum_q;
  logic                     p_first_q;
  logic                     p_last_q;
  logic                     p_valid_q;
  logic signed [ACC_BW-1:0] p_ext;
  logic signed [ACC_BW-1:0] psum_ext;
  logic signed [ACC_BW-1:0] acc_d;
  logic signed [ACC_BW-1:0] acc_q;
  logic                     done_q;

  assign p_d      = i_x * i_w;
  assign p_ext    = {{(ACC_BW - P_BW){p_q[P_BW-1]}}, p_q};
  assign psum_ext = {{(ACC_BW - I_BW){psum_q[I_BW-1]}}, psum_q};

  // Stage 1: register the product with its tags; tags and psum only move on a valid tap
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_q       <= '0;
      psum_q    <= '0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
      p_valid_q <= 1'b0;
    end else if (i_clear) begin
      p_valid_q <= 1'b0;
    end else begin
      p_valid_q <= i_valid;
      if (i_valid) begin
        p_q       <= p_d;
        p_first_q <= i_first;
        p_last_q  <= i_last;
        if (i_first) psum_q <= i_psum;
      end
    end
  end

  // Tap 0 reloads from psum so back-to-back windows need no bubble
  always_comb begin
    acc_d = p_first_q ? (psum_ext + p_ext) : (acc_q + p_ext);
  end

  // Stage 2: accumulate valid products; done strobes once the last product is folded in
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q  <= '0;
      done_q <= 1'b0;
    end else if (i_clear) begin
      done_q <= 1'b0;
    end else begin
      done_q <= p_valid_q & p_last_q;
      if (p_valid_q) acc_q <= acc_d;
    end
  end

  assign o_acc     = acc_q;
  assign o_p_valid = p_valid_q;
  assign o_done    = done_q;

endmodule

// File: rtl/convolution_kxk.sv
// rtl/convolution_kxk.sv - serial KxK MAC window with saturated output; optional CONV_RELU_EN clamps negatives to 0
module convolution_kxk
  import conv_pkg::*;
#(
  parameter int K    = CONV_K_DEF,
  parameter int X_BW = CONV_X_BW_DEF,
  parameter int W_BW = CONV_W_BW_DEF,
  parameter int I_BW = CONV_I_BW_DEF,
  parameter int O_BW = CONV_O_BW_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic signed [X_BW-1:0] i_x,
  input  logic signed [W_BW-1:0] i_w,
  input  logic signed [I_BW-1:0] i_psum,
  input  logic                   i_clear,
  output logic signed [O_BW-1:0] o_y,
  output logic                   o_valid,
  output logic                   o_busy
);

  localparam int NTAP   = K * K;
  localparam int TAP_W  = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int ACC_BW = conv_acc_bw(I_BW, X_BW, W_BW, K);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAP - 1);

  conv_state_e              state_q;
  conv_state_e              state_d;
  logic [TAP_W-1:0]         tap_q;
  logic [TAP_W-1:0]         tap_d;
  logic                     take;
  logic                     tap_first;
  logic                     tap_last;
  logic signed [ACC_BW-1:0] acc;
  logic                     p_valid;
  logic                     done;
  logic signed [CONV_SAT_W-1:0] acc_ext;
  logic signed [O_BW-1:0]   y_sat;
  logic signed [O_BW-1:0]   y_d;
  logic signed [O_BW-1:0]   y_q;
  logic                     valid_q;

  // A clear in the same cycle swallows the tap
  assign take      = i_valid & ~i_clear;
  assign tap_first = (tap_q == '0);
  assign tap_last  = (tap_q == LAST_TAP);

  // Next tap index and window state; wraps after the last tap, clear returns to tap 0
  always_comb begin
    tap_d   = tap_q;
    state_d = state_q;
    if (i_clear) begin
      tap_d   = '0;
      state_d = CONV_IDLE;
    end else if (i_valid) begin
      tap_d   = tap_last ? '0 : (tap_q + TAP_W'(1));
      state_d = (tap_d == '0) ? CONV_IDLE : CONV_ACCUM;
    end
  end

  // Tap counter / window FSM registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tap_q   <= '0;
      state_q <= CONV_IDLE;
    end else begin
      tap_q   <= tap_d;
      state_q <= state_d;
    end
  end

  conv_mac_pe #(
    .X_BW   (X_BW),
    .W_BW   (W_BW),
    .I_BW   (I_BW),
    .ACC_BW (ACC_BW)
  ) u_mac (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (i_clear),
    .i_valid   (take),
    .i_first   (tap_first),
    .i_last    (tap_last),
    .i_x       (i_x),
    .i_w       (i_w),
    .i_psum    (i_psum),
    .o_acc     (acc),
    .o_p_valid (p_valid),
    .o_done    (done)
  );

  assign acc_ext = {{(CONV_SAT_W - ACC_BW){acc[ACC_BW-1]}}, acc};
  assign y_sat   = O_BW'(conv_sat(acc_ext, ACC_BW, O_BW));

  // Optional rectification applied after saturation
  always_comb begin
    y_d = y_sat;
`ifdef CONV_RELU_EN
    if (y_sat[O_BW-1]) y_d = '0;
`endif
  end

  // Result register: o_y only changes on a delivered result; a clear drops the pending one
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= done & ~i_clear;
      if (done && !i_clear) y_q <= y_d;
    end
  end

  assign o_y     = y_q;
  assign o_valid = valid_q;
  assign o_busy  = (state_q != CONV_IDLE) | p_valid | done;

endmodule

// File: tb/tb_convolution_kxk.sv
// tb/tb_convolution_kxk.sv - scoreboard bench for convolution_kxk (K=3)
module tb_convolution_kxk;

  localparam int K    = 3;
  localparam int X_BW = 8;
  localparam int W_BW = 8;
  localparam int I_BW = 19;
  localparam int O_BW = 19;
  localparam int NT   = K * K;

  logic                   i_clk   = 1'b0;
  logic                   i_rst_n = 1'b0;
  logic                   i_valid = 1'b0;
  logic                   i_clear = 1'b0;
  logic signed [X_BW-1:0] i_x     = '0;
  logic signed [W_BW-1:0] i_w     = '0;
  logic signed [I_BW-1:0] i_psum  = '0;
  logic signed [O_BW-1:0] o_y;
  logic                   o_valid;
  logic                   o_busy;

  convolution_kxk #(
    .K(K), .X_BW(X_BW), .W_BW(W_BW), .I_BW(I_BW), .O_BW(O_BW)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_x     (i_x),
    .i_w     (i_w),
    .i_psum  (i_psum),
    .i_clear (i_clear),
    .o_y     (o_y),
    .o_valid (o_valid),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int y;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total   = 0;
  int   bad     = 0;
  int   n_valid = 0;
  int   n_exp   = 0;
  int   last_y  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference result for a window of identical taps
  function automatic int model(input int psum, input int x, input int w);
    longint s;
    longint hi;
    longint lo;
    hi = (longint'(1) << (O_BW - 1)) - 1;
    lo = -(longint'(1) << (O_BW - 1));
    s  = longint'(psum) + longint'(NT) * longint'(x) * longint'(w);
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return int'(s);
  endfunction

  // Compare every delivered result against the scoreboard head, value and cycle
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid === 1'b1) begin
      n_valid++;
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("y", int'(o_y), e.y);
        check("latency", cyc, e.due);
      end
    end
  end

  task automatic step(input int x, input int w, input int psum, input logic v);
    i_valid = v;
    i_x     = X_BW'(x);
    i_w     = W_BW'(w);
    i_psum  = I_BW'(psum);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic run_window(input int x, input int w, input int psum, input int gap);
    for (int t = 0; t < NT; t++) begin
      step(x, w, psum, 1'b1);
      if (t == 0) check("busy_in_window", int'(o_busy), 1);
      if (t == NT - 1) begin
        sb.push_back('{model(psum, x, w), cyc + 2});
        last_y = model(psum, x, w);
        n_exp++;
      end
      for (int g = 0; g < gap; g++) step(0, 0, 0, 1'b0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1'b0);
    check("busy_idle", int'(o_busy), 0);
    check("y_hold", int'(o_y), last_y);
  endtask

  initial begin
    #1;
    check("rst_y", int'(o_y), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_busy", int'(o_busy), 0);
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    step(0, 0, 0, 1'b0);

    // continuous window
    run_window(100, 50, 0, 0);
    drain();
    // gapped window with negative psum
    run_window(100, 50, -5000, 1);
    drain();
    // back-to-back windows
    run_window(1, 1, 0, 0);
    run_window(-2, 3, 10, 0);
    drain();
    // positive saturation
    run_window(-128, -128, 200000, 0);
    drain();
    // negative result: ReLU or plain signed
    run_window(-128, 127, 0, 0);
    drain();

    // abort after four taps; the tap in the clear cycle is ignored
    for (int t = 0; t < 4; t++) step(7, 7, 123, 1'b1);
    i_clear = 1'b1;
    step(7, 7, 123, 1'b1);
    i_clear = 1'b0;
    check("busy_after_clear", int'(o_busy), 0);
    run_window(10, 5, 0, 0);
    drain();

    // reset in the middle of a window
    for (int t = 0; t < 5; t++) step(3, 3, 0, 1'b1);
    i_rst_n = 1'b0;
    #1;
    check("midrst_y", int'(o_y), 0);
    check("midrst_busy", int'(o_busy), 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    last_y  = 0;
    step(0, 0, 0, 1'b0);
    run_window(1, 1, 0, 0);
    drain();

    check("sb_empty", sb.size(), 0);
    check("n_valid", n_valid, n_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
